// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the DMA master's state type.
package ahb_pkg;

    // HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HSIZE encodings
    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // One state per AHB phase of a read-then-write word copy
    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR,
        WR_DATA,
        DONE,
        ERR
    } dma_state_t;

    // Force a byte address onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ahb_dma_master.sv
// AHB-Lite block-copy master: one word at a time, read then write,
// never overlapping an address phase with a data phase.
module ahb_dma_master
    import ahb_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 start,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [CNT_WIDTH-1:0] word_count,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [31:0]          HADDR,
    output logic [1:0]           HTRANS,
    output logic                 HWRITE,
    output logic [2:0]           HSIZE,
    output logic [31:0]          HWDATA,
    input  logic                 HREADY,
    input  logic                 HRESP,
    input  logic [31:0]          HRDATA
);

    dma_state_t           state_reg, state_next;
    logic [31:0]          src_reg, src_next;
    logic [31:0]          dst_reg, dst_next;
    logic [31:0]          buf_reg, buf_next;
    logic [31:0]          haddr_reg, haddr_next;
    logic                 hwrite_reg, hwrite_next;
    logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;

    // State, datapath and registered bus-address/control
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg  <= IDLE;
            src_reg    <= '0;
            dst_reg    <= '0;
            buf_reg    <= '0;
            haddr_reg  <= '0;
            hwrite_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            src_reg    <= src_next;
            dst_reg    <= dst_next;
            buf_reg    <= buf_next;
            haddr_reg  <= haddr_next;
            hwrite_reg <= hwrite_next;
            cnt_reg    <= cnt_next;
        end
    end

    // Next-state logic; HADDR/HWRITE are loaded on entry to an address
    // phase so they stay put through the following data phase and idle
    always_comb begin
        state_next  = state_reg;
        src_next    = src_reg;
        dst_next    = dst_reg;
        buf_next    = buf_reg;
        haddr_next  = haddr_reg;
        hwrite_next = hwrite_reg;
        cnt_next    = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    src_next = word_align(src_addr);
                    dst_next = word_align(dst_addr);
                    cnt_next = word_count;
                    if (word_count == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next  = RD_ADDR;
                        haddr_next  = word_align(src_addr);
                        hwrite_next = 1'b0;
                    end
                end
            end
            RD_ADDR: begin
                if (HREADY) state_next = RD_DATA;
            end
            RD_DATA: begin
                // First cycle of an error response is enough to abort
                if (HRESP) begin
                    state_next = ERR;
                end else if (HREADY) begin
                    buf_next    = HRDATA;
                    state_next  = WR_ADDR;
                    haddr_next  = dst_reg;
                    hwrite_next = 1'b1;
                end
            end
            WR_ADDR: begin
                if (HREADY) state_next = WR_DATA;
            end
            WR_DATA: begin
                if (HRESP) begin
                    state_next = ERR;
                end else if (HREADY) begin
                    src_next = src_reg + 32'd4;
                    dst_next = dst_reg + 32'd4;
                    cnt_next = cnt_reg - CNT_WIDTH'(1);
                    if (cnt_reg == CNT_WIDTH'(1)) begin
                        state_next = DONE;
                    end else begin
                        state_next  = RD_ADDR;
                        haddr_next  = src_reg + 32'd4;
                        hwrite_next = 1'b0;
                    end
                end
            end
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from registers only
    assign HTRANS = (state_reg == RD_ADDR || state_reg == WR_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR  = haddr_reg;
    assign HWRITE = hwrite_reg;
    assign HSIZE  = HSIZE_WORD;
    assign HWDATA = (state_reg == WR_DATA) ? buf_reg : 32'd0;
    assign busy   = (state_reg != IDLE);
    assign done   = (state_reg == DONE);
    assign error  = (state_reg == ERR);

endmodule

// File: tb/tb_ahb_dma_master.sv
// Bench for ahb_dma_master: behavioural RAM slave, word-copy reference
// model feeding expectation queues, and a monitor that checks every
// completed write and every done/error pulse as it appears on the bus.
module tb_ahb_dma_master;

    localparam int CW = 16;

    logic          HCLK;
    logic          HRESETn = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   src_addr = '0;
    logic [31:0]   dst_addr = '0;
    logic [CW-1:0] word_count = '0;
    logic          busy, done, error;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [31:0]   HWDATA;
    logic          HREADY = 1'b1;
    logic          HRESP = 1'b0;
    logic [31:0]   HRDATA = '0;

    ahb_dma_master #(.CNT_WIDTH(CW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .word_count(word_count),
        .busy(busy), .done(done), .error(error),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { bit is_err; int at_cyc; int busy_n; int nonseq_n; } ev_t;

    wr_t exp_wr[$];
    ev_t exp_ev[$];

    logic [31:0] mem     [logic [31:0]];   // slave RAM (what the DUT touches)
    logic [31:0] ref_mem [logic [31:0]];   // reference model's RAM

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc = 0;

    // slave controls
    int sl_wait     = 0;
    int sl_err_at   = -1;
    int sl_rd_count = 0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_1E69;
    endfunction
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge HCLK) cyc <= cyc + 1;

    // AHB-Lite RAM slave: optional wait states on data phases, two-cycle
    // error response on a chosen read
    initial begin : slave
        bit          dp_act = 0, dp_write = 0, dp_err = 0;
        int          dp_wait = 0, dp_errcyc = 0;
        logic [31:0] dp_addr = '0;
        forever begin
            @(posedge HCLK);
            if (!HRESETn) begin
                dp_act = 0;
            end else begin
                if (dp_act && HREADY) begin
                    if (dp_write && !HRESP) mem[dp_addr] = HWDATA;
                    dp_act = 0;
                end
                if (HTRANS == 2'b10 && HREADY) begin
                    dp_act    = 1;
                    dp_addr   = HADDR;
                    dp_write  = HWRITE;
                    dp_wait   = sl_wait;
                    dp_err    = !HWRITE && (sl_rd_count == sl_err_at);
                    dp_errcyc = 0;
                    if (!HWRITE) sl_rd_count++;
                end
            end
            #1;
            if (dp_act && dp_err) begin
                HREADY = (dp_errcyc != 0);
                HRESP  = 1'b1;
                dp_errcyc = 1;
            end else if (dp_act && dp_wait > 0) begin
                HREADY = 1'b0;
                HRESP  = 1'b0;
                dp_wait--;
            end else begin
                HREADY = 1'b1;
                HRESP  = 1'b0;
                if (dp_act && !dp_write) HRDATA = mem_rd(dp_addr);
            end
        end
    end

    // Monitor: compares bus writes and completion pulses with the queues
    initial begin : monitor
        bit          wr_pend = 0, prev_wait = 0;
        logic [31:0] wr_addr = '0, prev_haddr = '0;
        logic [1:0]  prev_htrans = '0;
        logic        prev_hwrite = 1'b0;
        int          busy_cnt = 0, ns_cnt = 0;
        wr_t         w;
        ev_t         e;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                wr_pend = 0; prev_wait = 0; busy_cnt = 0; ns_cnt = 0;
            end else begin
                if (prev_wait) begin
                    check("hold_haddr", HADDR, prev_haddr);
                    check("hold_htrans", 32'(HTRANS), 32'(prev_htrans));
                    check("hold_hwrite", 32'(HWRITE), 32'(prev_hwrite));
                end
                prev_wait   = !HREADY && !HRESP;
                prev_haddr  = HADDR;
                prev_htrans = HTRANS;
                prev_hwrite = HWRITE;
                if (wr_pend && HREADY) begin
                    wr_pend = 0;
                    if (!HRESP) begin
                        if (exp_wr.size() == 0) begin
                            n_checks++; n_fail++;
                            $display("FAIL unexpected_write: got addr %h data %h, required none", wr_addr, HWDATA);
                        end else begin
                            w = exp_wr.pop_front();
                            check("wr_addr", wr_addr, w.addr);
                            check("wr_data", HWDATA, w.data);
                            $display("write addr=%h data=%h cycle=%0d", wr_addr, HWDATA, cyc);
                        end
                    end
                end
                if (HTRANS == 2'b10 && HREADY) begin
                    ns_cnt++;
                    check("hsize", 32'(HSIZE), 32'h2);
                    if (HWRITE) begin wr_pend = 1; wr_addr = HADDR; end
                end
                if (busy) busy_cnt++;
                if (done || error) begin
                    if (exp_ev.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_pulse: got done=%b error=%b, required none", done, error);
                    end else begin
                        e = exp_ev.pop_front();
                        check("pulse_kind", 32'({done, error}), e.is_err ? 32'h1 : 32'h2);
                        check("pulse_cycle", 32'(cyc), 32'(e.at_cyc));
                        check("busy_cycles", 32'(busy_cnt), 32'(e.busy_n));
                        check("nonseq_count", 32'(ns_cnt), 32'(e.nonseq_n));
                        $display("copy end %s cycle=%0d busy=%0d nonseq=%0d", error ? "error" : "done", cyc, busy_cnt, ns_cnt);
                    end
                    busy_cnt = 0;
                    ns_cnt   = 0;
                end
            end
        end
    end

    // Issue one start; the reference model does the copy word by word on
    // its own RAM and predicts writes and the completion pulse.
    // abort=1: only the first word is expected before a planned reset.
    task automatic issue_copy(input logic [31:0] src, input logic [31:0] dst,
                              input int n, input int err_at, input int w, input bit abort);
        logic [31:0] s_al, d_al, d;
        int words;
        bit is_err;
        ev_t e;
        @(posedge HCLK); #1;
        sl_wait = w; sl_err_at = err_at; sl_rd_count = 0;
        start = 1'b1; src_addr = src; dst_addr = dst; word_count = CW'(n);
        start_cyc = cyc;
        s_al   = src & 32'hFFFF_FFFC;
        d_al   = dst & 32'hFFFF_FFFC;
        is_err = (err_at >= 0 && err_at < n);
        words  = abort ? 1 : (is_err ? err_at : n);
        for (int i = 0; i < words; i++) begin
            d = ref_rd(s_al + 32'(4 * i));
            ref_mem[d_al + 32'(4 * i)] = d;
            exp_wr.push_back('{d_al + 32'(4 * i), d});
        end
        if (!abort) begin
            e.is_err   = is_err;
            e.at_cyc   = is_err ? start_cyc + 1 + err_at * (4 + 2 * w) + 2
                                : start_cyc + 1 + n * (4 + 2 * w);
            e.busy_n   = e.at_cyc - start_cyc;
            e.nonseq_n = is_err ? 2 * err_at + 1 : 2 * n;
            exp_ev.push_back(e);
        end
        $display("start src=%h dst=%h count=%0d waits=%0d err_at=%0d cycle=%0d", src, dst, n, w, err_at, start_cyc);
        @(posedge HCLK); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (exp_ev.size() != 0 && t < 3000) begin
            @(posedge HCLK);
            t++;
        end
        if (exp_ev.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL completion_timeout: %0d pulses still outstanding after %0d cycles", exp_ev.size(), t);
            exp_ev.delete();
        end
        @(negedge HCLK);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_htrans", 32'(HTRANS), 32'h0);
        check("writes_outstanding", 32'(exp_wr.size()), 32'h0);
        exp_wr.delete();
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int guard;
        logic [31:0] w1;
        // reset state
        repeat (2) @(negedge HCLK);
        check("rst_htrans", 32'(HTRANS), 32'h0);
        check("rst_haddr", HADDR, 32'h0);
        check("rst_hwrite", 32'(HWRITE), 32'h0);
        check("rst_hwdata", HWDATA, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done_error", 32'({done, error}), 32'h0);
        check("rst_hsize", 32'(HSIZE), 32'h2);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;

        // zero-wait copy of three known words
        mem[32'h10] = 32'h1111_1111; ref_mem[32'h10] = 32'h1111_1111;
        mem[32'h14] = 32'h2222_2222; ref_mem[32'h14] = 32'h2222_2222;
        mem[32'h18] = 32'h3333_3333; ref_mem[32'h18] = 32'h3333_3333;
        issue_copy(32'h10, 32'h100, 3, -1, 0, 0);
        wait_idle();
        check("ram_100", mem_rd(32'h100), 32'h1111_1111);
        check("ram_104", mem_rd(32'h104), 32'h2222_2222);
        check("ram_108", mem_rd(32'h108), 32'h3333_3333);

        // two wait states on every data phase
        issue_copy(32'h200, 32'h300, 2, -1, 2, 0);
        wait_idle();

        // zero-length copy
        issue_copy(32'h40, 32'h80, 0, -1, 0, 0);
        wait_idle();

        // error on the second read of four
        issue_copy(32'h400, 32'h500, 4, 1, 0, 0);
        wait_idle();
        check("err_first_written", 32'(mem.exists(32'h500)), 32'h1);
        check("err_second_unwritten", 32'(mem.exists(32'h504)), 32'h0);

        // start re-pulsed while busy is ignored
        issue_copy(32'h600, 32'h700, 3, -1, 1, 0);
        repeat (3) @(posedge HCLK);
        #1;
        start = 1'b1; src_addr = 32'h900; dst_addr = 32'hA00; word_count = CW'(5);
        @(posedge HCLK); #1;
        start = 1'b0;
        wait_idle();

        // unaligned inputs and address wrap at the top of the map
        issue_copy(32'hFFFF_FFF9, 32'hFFFF_FFFE, 3, -1, 0, 0);
        wait_idle();

        // reset during the write data phase of the second word
        issue_copy(32'hA00, 32'hB00, 4, -1, 0, 1);
        w1 = ref_rd(32'hA04);
        guard = 0;
        while (cyc != start_cyc + 8 && guard < 50) begin
            @(posedge HCLK); #2;
            guard++;
        end
        check("abort_wr_data_phase", HWDATA, w1);
        HRESETn = 1'b0;
        #1;
        check("abort_htrans", 32'(HTRANS), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_hwdata", HWDATA, 32'h0);
        check("abort_haddr", HADDR, 32'h0);
        check("abort_writes_seen", 32'(exp_wr.size()), 32'h0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        issue_copy(32'hC00, 32'hD00, 3, -1, 0, 0);
        wait_idle();

        // randomized copies
        for (int it = 0; it < 15; it++) begin
            logic [31:0] s, d;
            int n, w, ea;
            s  = 32'h1000 + (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(0, 3));
            d  = 32'h2000 + (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(0, 3));
            n  = $urandom_range(0, 6);
            w  = $urandom_range(0, 2);
            ea = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            issue_copy(s, d, n, ea, w, 0);
            wait_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_dma_master.md
Name: ahb_dma_master

Overview:
AHB-Lite initiator (bus master) that copies a block of 32-bit words from a source address to a destination address.
- Sits as the sole master on a secondary AHB-Lite bus segment, in front of the existing RAM slaves and the video/sprite memory.
- Used for frame-buffer and sprite-table bulk copies, so the CPU does not spend cycles on them.
- Control is a simple start/busy/done/error interface driven by a CPU-side register block.

Parameters:
CNT_WIDTH, 16, width of the word-count input; maximum transfer is 2**CNT_WIDTH-1 words.

Ports:
HCLK  input  1  bus clock; all logic is rising-edge.
HRESETn  input  1  asynchronous, active-low reset.
start  input  1  single-cycle request to begin a copy; ignored while busy.
src_addr  input  32  source byte address; bits [1:0] ignored (forced 0).
dst_addr  input  32  destination byte address; bits [1:0] ignored (forced 0).
word_count  input  CNT_WIDTH  number of words to copy.
busy  output  1  high from the cycle after an accepted start until done or error.
done  output  1  one-cycle pulse on successful completion.
error  output  1  one-cycle pulse when the copy is aborted by HRESP.
HADDR  output  32  AHB address.
HTRANS  output  2  IDLE=2'b00 or NONSEQ=2'b10 only.
HWRITE  output  1  AHB write select.
HSIZE  output  3  fixed 3'b010 (word).
HWDATA  output  32  write data.
HREADY  input  1  bus ready (slave HREADYOUT after mux).
HRESP  input  1  slave error response.
HRDATA  input  32  read data.

Behaviour:
- Reset values: state IDLE, HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0, busy=0, done=0, error=0. The internal buffer, address registers and counter also reset to 0.
- Outputs are registered or decoded from the state register only. There is no combinational path from HRDATA/HREADY to the outputs, except that the buffer is captured from HRDATA.
- Transfers are non-overlapped. Each word is a read address phase, a read data phase, a write address phase and a write data phase. The next address phase is never issued during a data phase.
- State machine (transitions on HCLK rising edge):
  IDLE: start=1 → latch src/dst (bits[1:0]=0) and word_count. If word_count=0 go to DONE; else go to RD_ADDR.
  RD_ADDR: drive HADDR=src, HTRANS=NONSEQ, HWRITE=0. If HREADY=1 go to RD_DATA; else hold, with the address and control stable.
  RD_DATA: drive HTRANS=IDLE.
  - HREADY=1 and HRESP=0: capture HRDATA into the buffer and go to WR_ADDR.
  - HRESP=1: go to ERR.
  WR_ADDR: drive HADDR=dst, HTRANS=NONSEQ, HWRITE=1. If HREADY=1 go to WR_DATA.
  WR_DATA: drive HWDATA=buffer, HTRANS=IDLE.
  - HREADY=1 and HRESP=0: src+=4, dst+=4, count-=1. If the new count is 0 go to DONE; else go to RD_ADDR.
  - HRESP=1: go to ERR.
  DONE: done=1 for one cycle, then IDLE.
  ERR: error=1 for one cycle, then IDLE. The remaining count is discarded.
- HWDATA is 0 in every state except WR_DATA. HADDR holds its last value while HTRANS=IDLE.
- busy=1 in every state except IDLE.
- Latency:
  - Start sampled at edge k → NONSEQ visible in cycle k+1.
  - Zero-wait copy of N words takes 4N cycles, then one DONE cycle. done is asserted in cycle k+1+4N.
  - Each slave wait state adds one cycle to the phase it extends.
- Address arithmetic is modulo 2**32; wrap from 0xFFFFFFFC to 0x00000000 is silent.
- Simultaneous start with DONE/ERR: start is ignored. start is accepted only in IDLE.
- HRESP in an address phase is not possible by protocol; it is only evaluated in data-phase states.
- The first error cycle (HREADY=0, HRESP=1) is sufficient to trigger ERR. HTRANS is already IDLE, so the mandatory cancellation is met.
- Reset mid-copy: all state returns to reset values asynchronously. No done or error pulse is produced.

Decomposition:
- Package ahb_pkg holds:
  - HTRANS codes: IDLE, BUSY, NONSEQ, SEQ.
  - HSIZE codes: BYTE, HALF, WORD.
  - A typedef enum dma_state_t {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, DONE, ERR}.
- Single module, no sub-module. The address/counter datapath and the FSM are small enough to live together.

Test Plan:
- Zero-wait copy, src=0x0000_0010, dst=0x0000_0100, count=3, slave RAM preloaded 0x11111111/0x22222222/0x33333333 → RAM[0x100..0x108] holds the same values. done is high exactly 13 cycles after the start cycle; busy is high for 13 cycles.
- Slave inserts 2 wait states on every data phase, count=2 → HADDR/HTRANS/HWRITE stable during the waits. Data copies correctly; done at 1+8+8=17 cycles.
- count=0 → no NONSEQ is ever driven. done pulses 1 cycle after start; busy is high for 1 cycle.
- Slave returns HRESP=1 on the 2nd read of count=4 → exactly 1 write completed. error pulses once and done never asserts; the FSM returns to IDLE and HTRANS=IDLE.
- start re-pulsed while busy with different addresses → ignored; the original copy completes unchanged.
- Assert HRESETn=0 during WR_DATA of word 2 → HTRANS=IDLE, busy=0, HWDATA=0 immediately. A subsequent start copies correctly from the new arguments.
